control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
Hardwired Moore-style control sequencer for the bus-based 32-bit CPU.
- Sits directly upstream of the datapath and drives every datapath control strobe, one step per clock.
- Runs the three-step instruction fetch, then the execute steps selected by the 5-bit opcode the datapath decodes from IR[31:27].
- Handles halt/stop and reset.

Parameters:
UNKNOWN_AS_NOP, 1, 1 = undefined opcodes (11100-11111) execute as nop; 0 = they halt the machine

Ports:
clk  input  1  system clock, all state updates on rising edge
clr  input  1  synchronous active-high reset
opcode  input  5  IR[31:27] from datapath; stable from T3 until the next T2
con_out  input  1  branch condition flip-flop output from datapath
stop  input  1  request halt at instruction boundary
run  output  1  1 while executing, 0 in RESET/HALT
pc_out, pc_enable, pc_increment  output  1 each  PC bus drive / load / increment
mdr_out, mdr_enable, mdr_read, mar_enable, ram_enable  output  1 each  memory path controls
ir_enable, y_enable, zlo_enable, zhi_enable, zlo_out, zhi_out  output  1 each  IR/Y/Z controls
hi_enable, lo_enable, hi_out, lo_out  output  1 each  HI/LO controls
gra, grb, grc, r_in, r_out, ba_out, c_out, con_enable  output  1 each  select-encode, immediate and CON-FF controls
inport_out, outport_enable  output  1 each  I/O port controls

Behaviour:
- States: RESET, T0..T7, HALT. Outputs are decoded combinationally from the registered state and opcode only; they are glitch-tolerant and sampled by the datapath on the rising edge that ends the step.
- clr=1 at any edge: next state RESET, regardless of the current step; an in-flight instruction is abandoned with no further strobes. RESET: all outputs 0, run=0. Next state T0.
- All strobes not listed for a step are 0. run=1 in T0..T7.
- Fetch, common to all instructions:
  - T0: pc_out, mar_enable, pc_increment
  - T1: mdr_read, mdr_enable
  - T2: mdr_out, ir_enable
- Execute (opcode binary value: steps):
  - add/sub/and/or/shr/shra/shl/ror/rol (00011-01011): T3 grb,r_out,y_enable; T4 grc,r_out,zlo_enable; T5 zlo_out,gra,r_in.
  - addi/andi/ori (01100-01110): T3 grb,r_out,y_enable; T4 c_out,zlo_enable; T5 zlo_out,gra,r_in.
  - mul/div (01111,10000): T3 gra,r_out,y_enable; T4 grb,r_out,zlo_enable,zhi_enable; T5 zlo_out,lo_enable; T6 zhi_out,hi_enable.
  - neg/not (10001,10010): T3 grb,r_out,zlo_enable; T4 zlo_out,gra,r_in.
  - ld (00000): T3 grb,ba_out,y_enable; T4 c_out,zlo_enable; T5 zlo_out,mar_enable; T6 mdr_read,mdr_enable; T7 mdr_out,gra,r_in.
  - ldi (00001): T3-T4 as ld; T5 zlo_out,gra,r_in.
  - st (00010): T3-T5 as ld; T6 gra,r_out,mdr_enable (mdr_read=0); T7 ram_enable.
  - br (10011): T3 gra,r_out,con_enable; T4 pc_out,y_enable; T5 c_out,zlo_enable; T6 zlo_out, plus pc_enable only if con_out=1 during T6.
  - jr (10100): T3 gra,r_out,pc_enable.
  - jal (10101): T3 pc_out,grb,r_in; T4 gra,r_out,pc_enable.
  - in (10110): T3 inport_out,gra,r_in.
  - out (10111): T3 gra,r_out,outport_enable.
  - mfhi (11000): T3 hi_out,gra,r_in.
  - mflo (11001): T3 lo_out,gra,r_in.
  - nop (11010): no execute step; T2 goes straight to T0.
  - halt (11011): T2 goes to HALT.
- Last step of an instruction: the next state is T0, or HALT if stop=1 at that edge. stop is ignored in other steps.
- HALT: all outputs 0, run=0. Held until clr=1.
- Undefined opcodes: handled as nop or halt, per UNKNOWN_AS_NOP.
- Exactly one bus-driving strobe is active per step: pc_out, mdr_out, zlo_out, zhi_out, hi_out, lo_out, c_out, inport_out, or r_out with ba_out.
- Cycle counts, fetch included:
  - nop: 3
  - jr/in/out/mfhi/mflo: 4
  - jal/neg/not: 5
  - ALU/imm/ldi: 6
  - mul/div/br: 7
  - ld/st: 8

Test Plan:
- clr=1 for 2 cycles, then 0, with opcode=00011 (add) -> RESET, then T0..T5, then T0. T3 asserts grb,r_out,y_enable; T4 grc,r_out,zlo_enable; T5 zlo_out,gra,r_in. run=1 from T0.
- opcode=00000 (ld) -> 8-cycle sequence. mdr_read=1 in T1 and T6 only; mar_enable in T0 and T5; gra,r_in in T7.
- opcode=10011 (br) with con_out=0 -> pc_enable=0 in every step. Repeat with con_out=1 -> pc_enable=1 in T6 only.
- opcode=10110 (in), then opcode=11011 (halt) -> 4 cycles for in (inport_out,gra,r_in in T3). halt reaches HALT after T2 with run=0 and all strobes 0 for 10+ cycles; a clr pulse restarts at T0.
- opcode=00010 (st), clr=1 during T6 -> next state RESET; ram_enable never asserted.
- opcode=01111 (mul) with stop=1 held throughout -> completes T0..T6 (lo_enable in T5, hi_enable in T6), then HALT with run=0.

Source files
------------

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the bus-based 32-bit CPU.
// Steps fetch T0-T2, then opcode-selected execute steps T3-T7.
module control_unit #(
  parameter bit UNKNOWN_AS_NOP = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [4:0] opcode,
  input  logic       con_out,
  input  logic       stop,
  output logic       run,
  output logic       pc_out,
  output logic       pc_enable,
  output logic       pc_increment,
  output logic       mdr_out,
  output logic       mdr_enable,
  output logic       mdr_read,
  output logic       mar_enable,
  output logic       ram_enable,
  output logic       ir_enable,
  output logic       y_enable,
  output logic       zlo_enable,
  output logic       zhi_enable,
  output logic       zlo_out,
  output logic       zhi_out,
  output logic       hi_enable,
  output logic       lo_enable,
  output logic       hi_out,
  output logic       lo_out,
  output logic       gra,
  output logic       grb,
  output logic       grc,
  output logic       r_in,
  output logic       r_out,
  output logic       ba_out,
  output logic       c_out,
  output logic       con_enable,
  output logic       inport_out,
  output logic       outport_enable
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t state, next_state;

  logic ld, ldi, st, alu, imm, muldiv, negnot;
  logic br, jr, jal, in_op, out_op, mfhi, mflo;
  logic unk, hlt;
  logic in_t;
  logic [2:0] step, last;

  assign ld     = opcode == 5'd0;
  assign ldi    = opcode == 5'd1;
  assign st     = opcode == 5'd2;
  assign alu    = opcode >= 5'd3 && opcode <= 5'd11;
  assign imm    = opcode >= 5'd12 && opcode <= 5'd14;
  assign muldiv = opcode == 5'd15 || opcode == 5'd16;
  assign negnot = opcode == 5'd17 || opcode == 5'd18;
  assign br     = opcode == 5'd19;
  assign jr     = opcode == 5'd20;
  assign jal    = opcode == 5'd21;
  assign in_op  = opcode == 5'd22;
  assign out_op = opcode == 5'd23;
  assign mfhi   = opcode == 5'd24;
  assign mflo   = opcode == 5'd25;
  assign unk    = opcode >= 5'd28;
  assign hlt    = opcode == 5'd27 || (unk && !UNKNOWN_AS_NOP);

  assign in_t = state >= S_T0 && state <= S_T7;
  assign step = 3'(state - S_T0);

  // Final step index; nop, halt and undefined opcodes end at T2
  always_comb begin
    last = 3'd2;
    unique case (1'b1)
      alu, imm, ldi:               last = 3'd5;
      muldiv, br:                  last = 3'd6;
      ld, st:                      last = 3'd7;
      negnot, jal:                 last = 3'd4;
      jr, in_op, out_op, mfhi, mflo: last = 3'd3;
      default:                     last = 3'd2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state <= S_RESET;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (state == S_RESET) begin
      next_state = S_T0;
    end else if (in_t) begin
      if (state == S_T2 && hlt)
        next_state = S_HALT;
      else if (step == last)
        next_state = stop ? S_HALT : S_T0;
      else
        next_state = state_t'(state + 4'd1);
    end
    if (clr) next_state = S_RESET;
  end

  always_comb begin
    run = in_t;
    pc_out = 1'b0; pc_enable = 1'b0; pc_increment = 1'b0;
    mdr_out = 1'b0; mdr_enable = 1'b0; mdr_read = 1'b0;
    mar_enable = 1'b0; ram_enable = 1'b0; ir_enable = 1'b0;
    y_enable = 1'b0; zlo_enable = 1'b0; zhi_enable = 1'b0;
    zlo_out = 1'b0; zhi_out = 1'b0;
    hi_enable = 1'b0; lo_enable = 1'b0;
    hi_out = 1'b0; lo_out = 1'b0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0;
    r_in = 1'b0; r_out = 1'b0; ba_out = 1'b0; c_out = 1'b0;
    con_enable = 1'b0; inport_out = 1'b0; outport_enable = 1'b0;
    case (state)
      S_T0: begin
        pc_out = 1'b1; mar_enable = 1'b1; pc_increment = 1'b1;
      end
      S_T1: begin
        mdr_read = 1'b1; mdr_enable = 1'b1;
      end
      S_T2: begin
        mdr_out = 1'b1; ir_enable = 1'b1;
      end
      S_T3: begin
        unique case (1'b1)
          alu, imm:  begin grb = 1'b1; r_out = 1'b1; y_enable = 1'b1; end
          muldiv:    begin gra = 1'b1; r_out = 1'b1; y_enable = 1'b1; end
          negnot:    begin grb = 1'b1; r_out = 1'b1; zlo_enable = 1'b1; end
          ld, ldi, st: begin grb = 1'b1; ba_out = 1'b1; y_enable = 1'b1; end
          br:        begin gra = 1'b1; r_out = 1'b1; con_enable = 1'b1; end
          jr:        begin gra = 1'b1; r_out = 1'b1; pc_enable = 1'b1; end
          jal:       begin pc_out = 1'b1; grb = 1'b1; r_in = 1'b1; end
          in_op:     begin inport_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
          out_op:    begin gra = 1'b1; r_out = 1'b1; outport_enable = 1'b1; end
          mfhi:      begin hi_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
          mflo:      begin lo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        unique case (1'b1)
          alu:       begin grc = 1'b1; r_out = 1'b1; zlo_enable = 1'b1; end
          imm, ld, ldi, st: begin c_out = 1'b1; zlo_enable = 1'b1; end
          muldiv: begin
            grb = 1'b1; r_out = 1'b1;
            zlo_enable = 1'b1; zhi_enable = 1'b1;
          end
          negnot:    begin zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
          br:        begin pc_out = 1'b1; y_enable = 1'b1; end
          jal:       begin gra = 1'b1; r_out = 1'b1; pc_enable = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        unique case (1'b1)
          alu, imm, ldi: begin zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
          muldiv:    begin zlo_out = 1'b1; lo_enable = 1'b1; end
          ld, st:    begin zlo_out = 1'b1; mar_enable = 1'b1; end
          br:        begin c_out = 1'b1; zlo_enable = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        unique case (1'b1)
          muldiv:    begin zhi_out = 1'b1; hi_enable = 1'b1; end
          ld:        begin mdr_read = 1'b1; mdr_enable = 1'b1; end
          st:        begin gra = 1'b1; r_out = 1'b1; mdr_enable = 1'b1; end
          br:        begin zlo_out = 1'b1; pc_enable = con_out; end
          default: ;
        endcase
      end
      S_T7: begin
        unique case (1'b1)
          ld:        begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
          st:        ram_enable = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit; per-cycle expected strobe words
// queued by the driver and checked by an independent monitor.
module tb_control_unit;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic [4:0] opcode = 5'd3;
  logic con_out = 1'b0;
  logic stop = 1'b0;

  logic run, pc_out, pc_enable, pc_increment;
  logic mdr_out, mdr_enable, mdr_read, mar_enable, ram_enable;
  logic ir_enable, y_enable, zlo_enable, zhi_enable, zlo_out, zhi_out;
  logic hi_enable, lo_enable, hi_out, lo_out;
  logic gra, grb, grc, r_in, r_out, ba_out, c_out, con_enable;
  logic inport_out, outport_enable;

  control_unit #(.UNKNOWN_AS_NOP(1'b1)) dut (
    .clk(clk), .clr(clr), .opcode(opcode), .con_out(con_out),
    .stop(stop), .run(run), .pc_out(pc_out), .pc_enable(pc_enable),
    .pc_increment(pc_increment), .mdr_out(mdr_out),
    .mdr_enable(mdr_enable), .mdr_read(mdr_read),
    .mar_enable(mar_enable), .ram_enable(ram_enable),
    .ir_enable(ir_enable), .y_enable(y_enable),
    .zlo_enable(zlo_enable), .zhi_enable(zhi_enable),
    .zlo_out(zlo_out), .zhi_out(zhi_out), .hi_enable(hi_enable),
    .lo_enable(lo_enable), .hi_out(hi_out), .lo_out(lo_out),
    .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out),
    .ba_out(ba_out), .c_out(c_out), .con_enable(con_enable),
    .inport_out(inport_out), .outport_enable(outport_enable)
  );

  always #5 clk = ~clk;

  localparam logic [28:0] RUN = 29'd1 << 28;
  localparam logic [28:0] PCO = 29'd1 << 27;
  localparam logic [28:0] PCE = 29'd1 << 26;
  localparam logic [28:0] PCI = 29'd1 << 25;
  localparam logic [28:0] MDO = 29'd1 << 24;
  localparam logic [28:0] MDE = 29'd1 << 23;
  localparam logic [28:0] MDR = 29'd1 << 22;
  localparam logic [28:0] MAE = 29'd1 << 21;
  localparam logic [28:0] RAM = 29'd1 << 20;
  localparam logic [28:0] IRE = 29'd1 << 19;
  localparam logic [28:0] YE  = 29'd1 << 18;
  localparam logic [28:0] ZLE = 29'd1 << 17;
  localparam logic [28:0] ZHE = 29'd1 << 16;
  localparam logic [28:0] ZLO = 29'd1 << 15;
  localparam logic [28:0] ZHO = 29'd1 << 14;
  localparam logic [28:0] HIE = 29'd1 << 13;
  localparam logic [28:0] LOE = 29'd1 << 12;
  localparam logic [28:0] HIO = 29'd1 << 11;
  localparam logic [28:0] LOO = 29'd1 << 10;
  localparam logic [28:0] GA  = 29'd1 << 9;
  localparam logic [28:0] GB  = 29'd1 << 8;
  localparam logic [28:0] GC  = 29'd1 << 7;
  localparam logic [28:0] RI  = 29'd1 << 6;
  localparam logic [28:0] RO  = 29'd1 << 5;
  localparam logic [28:0] BAO = 29'd1 << 4;
  localparam logic [28:0] CO  = 29'd1 << 3;
  localparam logic [28:0] CNE = 29'd1 << 2;
  localparam logic [28:0] INO = 29'd1 << 1;
  localparam logic [28:0] OPE = 29'd1 << 0;

  localparam logic [28:0] F0 = RUN | PCO | MAE | PCI;
  localparam logic [28:0] F1 = RUN | MDR | MDE;
  localparam logic [28:0] F2 = RUN | MDO | IRE;

  logic [28:0] act;
  assign act = {run, pc_out, pc_enable, pc_increment, mdr_out,
                mdr_enable, mdr_read, mar_enable, ram_enable,
                ir_enable, y_enable, zlo_enable, zhi_enable, zlo_out,
                zhi_out, hi_enable, lo_enable, hi_out, lo_out, gra,
                grb, grc, r_in, r_out, ba_out, c_out, con_enable,
                inport_out, outport_enable};

  logic [28:0] exp_q[$];
  string name_q[$];
  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [28:0] e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s: got %h expected %h", n, act, e);
      end
    end
  end

  initial begin
    #100000;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL timeout: sequence did not finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic cyc(input logic [28:0] e, input string n);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(negedge clk);
    #1;
  endtask

  task automatic fetch(input logic [4:0] op, input string n);
    cyc(F0, {n, "_t0"});
    opcode = op;
    cyc(F1, {n, "_t1"});
    cyc(F2, {n, "_t2"});
  endtask

  initial begin
    clr = 1'b1;
    opcode = 5'b00011;
    cyc('0, "reset0");
    checks++;
    if (run !== 1'b0 || act !== '0) begin
      failures++;
      $display("FAIL reset_state: run=%b act=%h", run, act);
    end
    cyc('0, "reset1");
    clr = 1'b0;

    fetch(5'b00011, "add");
    cyc(RUN | GB | RO | YE, "add_t3");
    cyc(RUN | GC | RO | ZLE, "add_t4");
    cyc(RUN | ZLO | GA | RI, "add_t5");

    fetch(5'b00000, "ld");
    cyc(RUN | GB | BAO | YE, "ld_t3");
    cyc(RUN | CO | ZLE, "ld_t4");
    cyc(RUN | ZLO | MAE, "ld_t5");
    cyc(RUN | MDR | MDE, "ld_t6");
    cyc(RUN | MDO | GA | RI, "ld_t7");

    fetch(5'b10011, "br0");
    cyc(RUN | GA | RO | CNE, "br0_t3");
    cyc(RUN | PCO | YE, "br0_t4");
    cyc(RUN | CO | ZLE, "br0_t5");
    cyc(RUN | ZLO, "br0_t6");

    con_out = 1'b1;
    fetch(5'b10011, "br1");
    cyc(RUN | GA | RO | CNE, "br1_t3");
    cyc(RUN | PCO | YE, "br1_t4");
    cyc(RUN | CO | ZLE, "br1_t5");
    cyc(RUN | ZLO | PCE, "br1_t6");
    con_out = 1'b0;

    fetch(5'b01100, "addi");
    cyc(RUN | GB | RO | YE, "addi_t3");
    cyc(RUN | CO | ZLE, "addi_t4");
    cyc(RUN | ZLO | GA | RI, "addi_t5");

    fetch(5'b10101, "jal");
    cyc(RUN | PCO | GB | RI, "jal_t3");
    cyc(RUN | GA | RO | PCE, "jal_t4");

    fetch(5'b11100, "unk");

    fetch(5'b10110, "in");
    cyc(RUN | INO | GA | RI, "in_t3");

    fetch(5'b11011, "halt");
    for (int i = 0; i < 11; i++) cyc('0, "halted");
    clr = 1'b1;
    cyc('0, "clr_reset");
    clr = 1'b0;

    fetch(5'b00010, "st");
    cyc(RUN | GB | BAO | YE, "st_t3");
    cyc(RUN | CO | ZLE, "st_t4");
    cyc(RUN | ZLO | MAE, "st_t5");
    cyc(RUN | GA | RO | MDE, "st_t6");
    clr = 1'b1;
    cyc('0, "st_abort");
    clr = 1'b0;

    stop = 1'b1;
    fetch(5'b01111, "mul");
    cyc(RUN | GA | RO | YE, "mul_t3");
    cyc(RUN | GB | RO | ZLE | ZHE, "mul_t4");
    cyc(RUN | ZLO | LOE, "mul_t5");
    cyc(RUN | ZHO | HIE, "mul_t6");
    cyc('0, "mul_halt0");
    cyc('0, "mul_halt1");
    clr = 1'b1;
    cyc('0, "clr2");
    clr = 1'b0;

    fetch(5'b11010, "nop");
    cyc('0, "nop_stop_halt");
    stop = 1'b0;
    cyc('0, "nop_halt_hold");

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
